serial_subtractor: RTL

Bit-serial two's-complement subtractor computing diff = a − b, LSB-first, one bit per clock through a single registered borrow. It is the inverse arithmetic companion to the 1-bit full adder and ripple adder blocks. It sits beside those blocks wherever area matters more than latency. A start/busy/done handshake exchanges operands and results with the controlling logic.

---
 rtl/serial_subtractor.sv | 137 +++++++++++++
 1 files changed

// File: rtl/serial_subtractor.sv
// Bit-serial two's-complement subtractor: diff = a - b, LSB first, one bit per clock.
// start/busy/done handshake; results are held in output registers until the next commit.
module serial_subtractor #(
  parameter int NUM_BITS = 8
) (
  input  logic                clk,
  input  logic                n_rst,
  input  logic                start,
  input  logic [NUM_BITS-1:0] a,
  input  logic [NUM_BITS-1:0] b,
  output logic                busy,
  output logic                done,
  output logic [NUM_BITS-1:0] diff,
  output logic                borrow_out,
  output logic                overflow
);

  localparam int CNT_W = (NUM_BITS > 1) ? $clog2(NUM_BITS) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(NUM_BITS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state, state_next;

  logic                load;
  logic                step;
  logic                commit;

  logic [NUM_BITS-1:0] a_sr;
  logic [NUM_BITS-1:0] b_sr;
  logic [NUM_BITS-1:0] res_sr;
  logic [NUM_BITS-1:0] res_next;
  logic [CNT_W-1:0]    cnt;
  logic                brw;
  logic                brw_next;
  logic                d_bit;
  logic [1:0]          fs;

  // Returns {borrow_out, difference} of x - y - bin.
  function automatic logic [1:0] full_sub(input logic x, input logic y, input logic bin);
    logic dif;
    logic bout;
    dif  = x ^ y ^ bin;
    bout = (~x & y) | (~(x ^ y) & bin);
    return {bout, dif};
  endfunction

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    step       = 1'b0;
    commit     = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          load       = 1'b1;
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      RUN: begin
        step = 1'b1;
        if (cnt == LAST_BIT) begin
          commit     = 1'b1;
          state_next = DONE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign fs       = full_sub(a_sr[0], b_sr[0], brw);
  assign d_bit    = fs[0];
  assign brw_next = fs[1];
  assign res_next = {d_bit, res_sr[NUM_BITS-1:1]};

  // Bit-serial datapath: operand shifters, borrow flop, result shifter and bit counter.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      brw    <= 1'b0;
      cnt    <= '0;
    end else if (load) begin
      a_sr   <= a;
      b_sr   <= b;
      res_sr <= '0;
      brw    <= 1'b0;
      cnt    <= '0;
    end else if (step) begin
      a_sr   <= a_sr >> 1;
      b_sr   <= b_sr >> 1;
      res_sr <= res_next;
      brw    <= brw_next;
      cnt    <= cnt + CNT_W'(1);
    end
  end

  // Result registers change only on the commit edge; flags come from the MSB step.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      diff       <= '0;
      borrow_out <= 1'b0;
      overflow   <= 1'b0;
    end else if (commit) begin
      diff       <= res_next;
      borrow_out <= brw_next;
      overflow   <= brw ^ brw_next;
    end
  end

  // Handshake outputs are registered from the next state so they align with it.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_next == RUN);
      done <= (state_next == DONE);
    end
  end

endmodule
